// File: rtl/battleship_board_if.sv
// Handshake bundle for battleship_board: placement requests, shot requests
// and the one-cycle shot-result pulse. The game driver uses the master
// modport and the board uses the slave modport.
interface battleship_board_if #(
  parameter int IDX_W = 3
);
  // Placement channel
  logic             place_valid;
  logic             place_ready;
  logic             place_board;
  logic [IDX_W-1:0] place_row;
  logic [IDX_W-1:0] place_col;

  // Shot channel
  logic             shot_valid;
  logic             shot_ready;
  logic             shot_board;
  logic [IDX_W-1:0] shot_row;
  logic [IDX_W-1:0] shot_col;

  // Shot result
  logic             result_valid;
  logic [1:0]       result_code;

  modport master (
    output place_valid, place_board, place_row, place_col,
    output shot_valid, shot_board, shot_row, shot_col,
    input  place_ready, shot_ready,
    input  result_valid, result_code
  );

  modport slave (
    input  place_valid, place_board, place_row, place_col,
    input  shot_valid, shot_board, shot_row, shot_col,
    output place_ready, shot_ready,
    output result_valid, result_code
  );
endinterface

// File: rtl/battleship_board.sv
// battleship_board: game-state stage ahead of the VGA top.
// Holds the player and pc 5x5 boards as 4-bit cell codes, accepts ship
// placements during setup and shots afterwards, classifies each shot,
// keeps ship-cells-left counters and flags the winner.
// Board index 0 is the player board, index 1 is the pc board.
// Optional feature: define BATTLESHIP_SHOT_STATS_EN to add per-board
// accepted-shot counters (shots_player, shots_pc).
module battleship_board #(
  parameter int N      = 5,
  parameter int CELL_W = 4,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  battleship_board_if.slave     bus,
  output logic [CELL_W-1:0]     matriz_player_final [N][N],
  output logic [CELL_W-1:0]     matriz_pc_final     [N][N],
  output logic [CNT_W-1:0]      ships_left_player,
  output logic [CNT_W-1:0]      ships_left_pc,
  output logic                  game_over,
  output logic                  winner
`ifdef BATTLESHIP_SHOT_STATS_EN
  ,
  output logic [CNT_W-1:0]      shots_player,
  output logic [CNT_W-1:0]      shots_pc
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  typedef enum logic {
    SETUP = 1'b0,
    PLAY  = 1'b1
  } phase_t;

  localparam logic [CELL_W-1:0] CELL_EMPTY = CELL_W'(0);
  localparam logic [CELL_W-1:0] CELL_SHIP  = CELL_W'(1);
  localparam logic [CELL_W-1:0] CELL_HIT   = CELL_W'(2);
  localparam logic [CELL_W-1:0] CELL_MISS  = CELL_W'(3);

  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_HIT     = 2'b01;
  localparam logic [1:0] RES_REPEAT  = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N * N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t             state_reg;
  phase_t             phase_reg;
  logic               shot_board_reg;
  logic [IDX_W-1:0]   shot_row_reg;
  logic [IDX_W-1:0]   shot_col_reg;
  logic               result_valid_reg;
  logic [1:0]         result_code_reg;
  logic               game_over_reg;
  logic               winner_reg;

  logic [CELL_W-1:0]  board_reg      [2][N][N];
  logic [CNT_W-1:0]   ships_left_reg [2];

  // ------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------
  logic               shot_fire;
  logic               place_fire;
  logic               place_in_range;
  logic [CELL_W-1:0]  place_cell;
  logic               place_write;
  logic               shot_in_range;
  logic [CELL_W-1:0]  shot_cell;
  logic [1:0]         shot_class;
  logic               upd_hit;
  logic               upd_miss;

  logic               wr_en;
  logic               wr_board;
  logic [IDX_W-1:0]   wr_row;
  logic [IDX_W-1:0]   wr_col;
  logic [CELL_W-1:0]  wr_code;

  // Shots win over placements; placements close for good once play starts.
  assign bus.shot_ready  = (state_reg == IDLE) && !game_over_reg;
  assign bus.place_ready = (state_reg == IDLE) && (phase_reg == SETUP) && !bus.shot_valid;

  assign shot_fire  = bus.shot_valid  && bus.shot_ready;
  assign place_fire = bus.place_valid && bus.place_ready;

  // Look up the placement target; out-of-range targets never index the array.
  always_comb begin
    place_in_range = (int'(bus.place_row) < N) && (int'(bus.place_col) < N);
    place_cell     = CELL_EMPTY;
    if (place_in_range) begin
      place_cell = board_reg[bus.place_board][bus.place_row][bus.place_col];
    end
  end

  assign place_write = place_fire && place_in_range && (place_cell == CELL_EMPTY);

  // Classify the latched shot against the current cell contents.
  always_comb begin
    shot_in_range = (int'(shot_row_reg) < N) && (int'(shot_col_reg) < N);
    shot_cell     = CELL_EMPTY;
    shot_class    = RES_INVALID;
    if (shot_in_range) begin
      shot_cell = board_reg[shot_board_reg][shot_row_reg][shot_col_reg];
      if (shot_cell == CELL_SHIP) begin
        shot_class = RES_HIT;
      end else if (shot_cell == CELL_EMPTY) begin
        shot_class = RES_MISS;
      end else begin
        shot_class = RES_REPEAT;
      end
    end
  end

  assign upd_hit  = (state_reg == UPDATE) && (result_code_reg == RES_HIT);
  assign upd_miss = (state_reg == UPDATE) && (result_code_reg == RES_MISS);

  // Single board write port: placements in IDLE, shot results in UPDATE.
  always_comb begin
    wr_en    = 1'b0;
    wr_board = 1'b0;
    wr_row   = '0;
    wr_col   = '0;
    wr_code  = CELL_EMPTY;
    if (place_write) begin
      wr_en    = 1'b1;
      wr_board = bus.place_board;
      wr_row   = bus.place_row;
      wr_col   = bus.place_col;
      wr_code  = CELL_SHIP;
    end else if (upd_hit || upd_miss) begin
      wr_en    = 1'b1;
      wr_board = shot_board_reg;
      wr_row   = shot_row_reg;
      wr_col   = shot_col_reg;
      wr_code  = upd_hit ? CELL_HIT : CELL_MISS;
    end
  end

  // ------------------------------------------------------------------
  // Shot FSM with registered result and game-over flags
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      phase_reg        <= SETUP;
      shot_board_reg   <= 1'b0;
      shot_row_reg     <= '0;
      shot_col_reg     <= '0;
      result_valid_reg <= 1'b0;
      result_code_reg  <= RES_MISS;
      game_over_reg    <= 1'b0;
      winner_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          result_valid_reg <= 1'b0;
          if (shot_fire) begin
            shot_board_reg <= bus.shot_board;
            shot_row_reg   <= bus.shot_row;
            shot_col_reg   <= bus.shot_col;
            phase_reg      <= PLAY;
            state_reg      <= CHECK;
          end
        end
        CHECK: begin
          // Result is presented for the whole UPDATE cycle.
          result_code_reg  <= shot_class;
          result_valid_reg <= 1'b1;
          state_reg        <= UPDATE;
        end
        UPDATE: begin
          result_valid_reg <= 1'b0;
          if (upd_hit && (ships_left_reg[shot_board_reg] == CNT_ONE)) begin
            game_over_reg <= 1'b1;
            // Emptying the player board means the pc won.
            winner_reg    <= ~shot_board_reg;
          end
          state_reg <= IDLE;
        end
        default: begin
          result_valid_reg <= 1'b0;
          state_reg        <= IDLE;
        end
      endcase
    end
  end

  // Cell storage: one write per cycle, everything cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            board_reg[b][r][c] <= CELL_EMPTY;
          end
        end
      end
    end else if (wr_en) begin
      board_reg[wr_board][wr_row][wr_col] <= wr_code;
    end
  end

  // Ship-cells-left counters: saturating increment, no decrement below 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ships_left_reg[0] <= CNT_ZERO;
      ships_left_reg[1] <= CNT_ZERO;
    end else if (place_write) begin
      if (ships_left_reg[bus.place_board] != CNT_FULL) begin
        ships_left_reg[bus.place_board] <= ships_left_reg[bus.place_board] + CNT_ONE;
      end
    end else if (upd_hit) begin
      if (ships_left_reg[shot_board_reg] != CNT_ZERO) begin
        ships_left_reg[shot_board_reg] <= ships_left_reg[shot_board_reg] - CNT_ONE;
      end
    end
  end

`ifdef BATTLESHIP_SHOT_STATS_EN
  logic [CNT_W-1:0] shots_reg [2];

  // Every accepted shot counts, including repeats and invalid targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shots_reg[0] <= CNT_ZERO;
      shots_reg[1] <= CNT_ZERO;
    end else if (shot_fire && (shots_reg[bus.shot_board] != {CNT_W{1'b1}})) begin
      shots_reg[bus.shot_board] <= shots_reg[bus.shot_board] + CNT_ONE;
    end
  end

  assign shots_player = shots_reg[0];
  assign shots_pc     = shots_reg[1];
`endif

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.result_valid   = result_valid_reg;
  assign bus.result_code    = result_code_reg;
  assign ships_left_player  = ships_left_reg[0];
  assign ships_left_pc      = ships_left_reg[1];
  assign game_over          = game_over_reg;
  assign winner             = winner_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        assign matriz_player_final[gi][gj] = board_reg[0][gi][gj];
        assign matriz_pc_final[gi][gj]     = board_reg[1][gi][gj];
      end
    end
  endgenerate

endmodule

// File: tb/tb_battleship_board.sv
// Testbench for battleship_board: scenario tasks with inline checks and a
// result-code scoreboard fed at shot acceptance and drained by a monitor.
module tb_battleship_board;

  localparam int N      = 5;
  localparam int CELL_W = 4;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 5;

  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_HIT     = 2'b01;
  localparam logic [1:0] RES_REPEAT  = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  logic clk;
  logic rst;
  logic [CELL_W-1:0] m_player [N][N];
  logic [CELL_W-1:0] m_pc     [N][N];
  logic [CNT_W-1:0]  ships_left_player;
  logic [CNT_W-1:0]  ships_left_pc;
  logic              game_over;
  logic              winner;
`ifdef BATTLESHIP_SHOT_STATS_EN
  logic [CNT_W-1:0]  shots_player;
  logic [CNT_W-1:0]  shots_pc;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [1:0] exp_q [$];

  battleship_board_if #(.IDX_W(IDX_W)) bus ();

  battleship_board #(
    .N(N), .CELL_W(CELL_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .matriz_player_final (m_player),
    .matriz_pc_final     (m_pc),
    .ships_left_player   (ships_left_player),
    .ships_left_pc       (ships_left_pc),
    .game_over           (game_over),
    .winner              (winner)
`ifdef BATTLESHIP_SHOT_STATS_EN
    ,
    .shots_player        (shots_player),
    .shots_pc            (shots_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every result pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (!rst && bus.result_valid === 1'b1) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL result_unexpected: got code %b, required no result", bus.result_code);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (bus.result_code !== e)
          $display("FAIL result_code: got %b, required %b", bus.result_code, e);
        else
          pass_cnt++;
        $display("result: code=%b expected=%b", bus.result_code, e);
      end
    end
  end

  function automatic int count_code(input int b, input logic [CELL_W-1:0] code);
    int n = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if ((b == 0 ? m_player[r][c] : m_pc[r][c]) === code) n++;
    return n;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Placement expected to be accepted; ends on a negedge.
  task automatic do_place(input logic b, input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    int waited = 0;
    bus.place_valid = 1'b1; bus.place_board = b; bus.place_row = r; bus.place_col = c;
    while (bus.place_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check_cnt++;
      $display("FAIL place_timeout: place_ready=%b, required 1", bus.place_ready);
      bus.place_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.place_valid = 1'b0;
    @(negedge clk);
    $display("place: board=%0d row=%0d col=%0d", b, r, c);
  endtask

  // Shot with scoreboard entry and latency checks; ends on the negedge after UPDATE.
  task automatic do_shot(input logic b, input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c,
                         input logic [1:0] exp);
    int waited = 0;
    bus.shot_valid = 1'b1; bus.shot_board = b; bus.shot_row = r; bus.shot_col = c;
    while (bus.shot_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check_cnt++;
      $display("FAIL shot_timeout: shot_ready=%b, required 1", bus.shot_ready);
      bus.shot_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    #1 bus.shot_valid = 1'b0;
    $display("shot: board=%0d row=%0d col=%0d expect=%b", b, r, c, exp);
    @(negedge clk);
    check_cnt++;
    if (bus.result_valid !== 1'b0 || bus.shot_ready !== 1'b0)
      $display("FAIL check_cycle: result_valid=%b shot_ready=%b, required 0 0", bus.result_valid, bus.shot_ready);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (bus.result_valid !== 1'b1 || bus.shot_ready !== 1'b0)
      $display("FAIL result_latency: result_valid=%b shot_ready=%b, required 1 0", bus.result_valid, bus.shot_ready);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (bus.result_valid !== 1'b0)
      $display("FAIL result_pulse_width: result_valid=%b, required 0", bus.result_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic saw_rv;
    apply_reset();
    do_place(1'b1, 3'd1, 3'd1);
    do_place(1'b0, 3'd3, 3'd3);
    check_cnt++;
    if (ships_left_pc !== 5'd1 || ships_left_player !== 5'd1)
      $display("FAIL reset_preload: ships pc=%0d player=%0d, required 1 1", ships_left_pc, ships_left_player);
    else pass_cnt++;
    // Accept a hit on pc (1,1), then reset in the CHECK cycle.
    bus.shot_valid = 1'b1; bus.shot_board = 1'b1; bus.shot_row = 3'd1; bus.shot_col = 3'd1;
    @(posedge clk);
    #1 bus.shot_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_cnt++;
    if (count_code(0, 4'd0) != N*N || count_code(1, 4'd0) != N*N)
      $display("FAIL reset_cells: empty player=%0d pc=%0d, required %0d", count_code(0, 4'd0), count_code(1, 4'd0), N*N);
    else pass_cnt++;
    check_cnt++;
    if (ships_left_pc !== 5'd0 || ships_left_player !== 5'd0 || game_over !== 1'b0 || winner !== 1'b0)
      $display("FAIL reset_flags: pc=%0d player=%0d go=%b win=%b, required 0 0 0 0",
               ships_left_pc, ships_left_player, game_over, winner);
    else pass_cnt++;
    check_cnt++;
    if (bus.result_valid !== 1'b0 || bus.result_code !== 2'b00 || bus.shot_ready !== 1'b1 || bus.place_ready !== 1'b1)
      $display("FAIL reset_handshake: rv=%b code=%b shot_ready=%b place_ready=%b, required 0 00 1 1",
               bus.result_valid, bus.result_code, bus.shot_ready, bus.place_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    saw_rv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.result_valid !== 1'b0) saw_rv = 1'b1;
    end
    check_cnt++;
    if (saw_rv !== 1'b0) $display("FAIL reset_abort_pulse: result_valid seen=%b, required 0", saw_rv);
    else pass_cnt++;
  endtask

  task automatic test_place();
    apply_reset();
    do_place(1'b1, 3'd2, 3'd2);
    check_cnt++;
    if (m_pc[2][2] !== 4'd1 || ships_left_pc !== 5'd1)
      $display("FAIL place_ship: cell=%0d ships=%0d, required 1 1", m_pc[2][2], ships_left_pc);
    else pass_cnt++;
    do_place(1'b1, 3'd2, 3'd2);
    check_cnt++;
    if (m_pc[2][2] !== 4'd1 || ships_left_pc !== 5'd1 || count_code(1, 4'd1) != 1)
      $display("FAIL place_dup: cell=%0d ships=%0d, required 1 1", m_pc[2][2], ships_left_pc);
    else pass_cnt++;
    do_place(1'b1, 3'd5, 3'd0);
    check_cnt++;
    if (ships_left_pc !== 5'd1 || ships_left_player !== 5'd0)
      $display("FAIL place_out_of_range: pc=%0d player=%0d, required 1 0", ships_left_pc, ships_left_player);
    else pass_cnt++;
  endtask

  task automatic test_hit_game_over();
    do_shot(1'b1, 3'd2, 3'd2, RES_HIT);
    check_cnt++;
    if (m_pc[2][2] !== 4'd2 || ships_left_pc !== 5'd0)
      $display("FAIL hit_update: cell=%0d ships=%0d, required 2 0", m_pc[2][2], ships_left_pc);
    else pass_cnt++;
    check_cnt++;
    if (game_over !== 1'b1 || winner !== 1'b0 || bus.shot_ready !== 1'b0 || bus.place_ready !== 1'b0)
      $display("FAIL game_over: go=%b win=%b shot_ready=%b place_ready=%b, required 1 0 0 0",
               game_over, winner, bus.shot_ready, bus.place_ready);
    else pass_cnt++;
  endtask

  task automatic test_miss_repeat_invalid();
    apply_reset();
    do_place(1'b0, 3'd0, 3'd0);
    do_shot(1'b0, 3'd4, 3'd4, RES_MISS);
    check_cnt++;
    if (m_player[4][4] !== 4'd3 || ships_left_player !== 5'd1)
      $display("FAIL miss_update: cell=%0d ships=%0d, required 3 1", m_player[4][4], ships_left_player);
    else pass_cnt++;
    do_shot(1'b0, 3'd4, 3'd4, RES_REPEAT);
    check_cnt++;
    if (m_player[4][4] !== 4'd3 || count_code(0, 4'd3) != 1)
      $display("FAIL repeat_nowrite: cell=%0d misses=%0d, required 3 1", m_player[4][4], count_code(0, 4'd3));
    else pass_cnt++;
    do_shot(1'b0, 3'd5, 3'd0, RES_INVALID);
    check_cnt++;
    if (count_code(0, 4'd0) != N*N-2 || m_player[0][0] !== 4'd1 || ships_left_player !== 5'd1 || game_over !== 1'b0)
      $display("FAIL invalid_nowrite: empty=%0d ship=%0d ships=%0d go=%b, required %0d 1 1 0",
               count_code(0, 4'd0), m_player[0][0], ships_left_player, game_over, N*N-2);
    else pass_cnt++;
`ifdef BATTLESHIP_SHOT_STATS_EN
    check_cnt++;
    if (shots_player !== 5'd3 || shots_pc !== 5'd0)
      $display("FAIL shot_stats: player=%0d pc=%0d, required 3 0", shots_player, shots_pc);
    else pass_cnt++;
`endif
  endtask

  task automatic test_priority();
    logic saw_ready;
    apply_reset();
    bus.place_valid = 1'b1; bus.place_board = 1'b1; bus.place_row = 3'd0; bus.place_col = 3'd0;
    bus.shot_valid  = 1'b1; bus.shot_board  = 1'b1; bus.shot_row  = 3'd1; bus.shot_col  = 3'd1;
    #1;
    check_cnt++;
    if (bus.place_ready !== 1'b0 || bus.shot_ready !== 1'b1)
      $display("FAIL priority_ready: place_ready=%b shot_ready=%b, required 0 1", bus.place_ready, bus.shot_ready);
    else pass_cnt++;
    do_shot(1'b1, 3'd1, 3'd1, RES_MISS);
    saw_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.place_ready !== 1'b0) saw_ready = 1'b1;
    end
    bus.place_valid = 1'b0;
    check_cnt++;
    if (saw_ready !== 1'b0 || m_pc[0][0] !== 4'd0 || ships_left_pc !== 5'd0 || m_pc[1][1] !== 4'd3)
      $display("FAIL place_after_play: ready_seen=%b cell00=%0d ships=%0d cell11=%0d, required 0 0 0 3",
               saw_ready, m_pc[0][0], ships_left_pc, m_pc[1][1]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_place(1'b1, 3'd0, 3'd0);
    do_place(1'b1, 3'd0, 3'd1);
    do_place(1'b0, 3'd4, 3'd0);
    do_shot(1'b1, 3'd0, 3'd0, RES_HIT);
    check_cnt++;
    if (ships_left_pc !== 5'd1 || game_over !== 1'b0 || bus.shot_ready !== 1'b1)
      $display("FAIL b2b_first: ships=%0d go=%b shot_ready=%b, required 1 0 1", ships_left_pc, game_over, bus.shot_ready);
    else pass_cnt++;
    do_shot(1'b1, 3'd0, 3'd1, RES_HIT);
    check_cnt++;
    if (ships_left_pc !== 5'd0 || game_over !== 1'b1 || winner !== 1'b0 || ships_left_player !== 5'd1)
      $display("FAIL b2b_second: ships=%0d go=%b win=%b player=%0d, required 0 1 0 1",
               ships_left_pc, game_over, winner, ships_left_player);
    else pass_cnt++;
  endtask

  task automatic test_pc_wins();
    apply_reset();
    do_place(1'b0, 3'd1, 3'd2);
    do_place(1'b1, 3'd3, 3'd3);
    do_shot(1'b0, 3'd1, 3'd2, RES_HIT);
    check_cnt++;
    if (game_over !== 1'b1 || winner !== 1'b1 || m_player[1][2] !== 4'd2 || ships_left_pc !== 5'd1)
      $display("FAIL pc_wins: go=%b win=%b cell=%0d pc_ships=%0d, required 1 1 2 1",
               game_over, winner, m_player[1][2], ships_left_pc);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    bus.place_valid = 1'b0; bus.place_board = 1'b0; bus.place_row = '0; bus.place_col = '0;
    bus.shot_valid  = 1'b0; bus.shot_board  = 1'b0; bus.shot_row  = '0; bus.shot_col  = '0;
    @(negedge clk);
    test_reset();
    test_place();
    test_hit_game_over();
    test_miss_repeat_invalid();
    test_priority();
    test_back_to_back();
    test_pc_wins();
    repeat (3) @(negedge clk);
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
